// File: rtl/llsc_pkg.sv
// Shared types and the granule-tag helper for the multi-channel LL/SC reservation monitor.
package llsc_pkg;

    localparam int unsigned ADDR_W_DEF    = 32;
    localparam int unsigned GRAN_BITS_DEF = 2;
    localparam int unsigned TAG_W         = ADDR_W_DEF - GRAN_BITS_DEF;
    // Widest byte address the tag helper accepts; callers zero-extend into it.
    localparam int unsigned MAX_ADDR_W    = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESV = 1'b1
    } resv_state_t;

    function automatic logic [MAX_ADDR_W-1:0] gran_tag(input logic [MAX_ADDR_W-1:0] addr,
                                                      input int gran_bits);
        return addr >> gran_bits;
    endfunction

endpackage

// File: rtl/llsc_entry.sv
// One channel's reservation: state, granule tag and (with LLSC_TIMEOUT_EN) an expiry counter.
module llsc_entry
    import llsc_pkg::*;
#(
    parameter int TW      = 30,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          sc,
    input  logic          ll,
    input  logic          kill,
    input  logic [TW-1:0] ll_tag,
    output logic          valid,
    output logic [TW-1:0] tag
);

    resv_state_t   state_r;
    logic [TW-1:0] tag_r;
    logic          expired_s;

`ifdef LLSC_TIMEOUT_EN
    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_r;

    assign expired_s = (state_r == RESV) && (cnt_r == CNT_MAX);

    // Age of the live reservation; restarts when an LL actually arms, saturates at TIMEOUT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (ll && !flush && !sc) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == RESV) && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end
`else
    // Reservations never expire in this build.
    assign expired_s = (TIMEOUT < 0);
`endif

    // Reservation FSM: flush > sc > ll > kill/expiry > hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            tag_r   <= {TW{1'b0}};
        end else if (flush) begin
            state_r <= IDLE;
        end else if (sc) begin
            state_r <= IDLE;
        end else if (ll) begin
            state_r <= RESV;
            tag_r   <= ll_tag;
        end else if (kill || expired_s) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_r;
        end
    end

    assign valid = (state_r == RESV);
    assign tag   = tag_r;

endmodule

// File: rtl/llsc_monitor.sv
// Multi-channel LL/SC reservation monitor: per-channel entries plus same-cycle SC arbitration and kill matrix.
// Optional reservation expiry is enabled by defining LLSC_TIMEOUT_EN.
module llsc_monitor
    import llsc_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int ADDR_W    = 32,
    parameter int GRAN_BITS = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NCH-1:0]        flush,
    input  logic [NCH-1:0]        ll_req,
    input  logic [NCH*ADDR_W-1:0] ll_addr,
    input  logic [NCH-1:0]        sc_req,
    input  logic [NCH*ADDR_W-1:0] sc_addr,
    input  logic                  st_valid,
    input  logic [ADDR_W-1:0]     st_addr,
    output logic [NCH-1:0]        sc_ok,
    output logic [NCH-1:0]        llbit
);

    localparam int TW = ADDR_W - GRAN_BITS;

    function automatic logic [TW-1:0] tag_of(input logic [ADDR_W-1:0] addr);
        return TW'(gran_tag(MAX_ADDR_W'(addr), GRAN_BITS));
    endfunction

    logic [TW-1:0]  ll_tag_s [NCH];
    logic [TW-1:0]  sc_tag_s [NCH];
    logic [TW-1:0]  tag_s    [NCH];
    logic [TW-1:0]  st_tag_s;
    logic [NCH-1:0] valid_s;
    logic [NCH-1:0] st_hit_s;
    logic [NCH-1:0] sc_cand_s;
    logic [NCH-1:0] blk_s;
    logic [NCH-1:0] sc_ok_s;
    logic [NCH-1:0] kill_s;

    assign st_tag_s = tag_of(st_addr);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign ll_tag_s[i] = tag_of(ll_addr[i*ADDR_W +: ADDR_W]);
        assign sc_tag_s[i] = tag_of(sc_addr[i*ADDR_W +: ADDR_W]);
        assign st_hit_s[i] = st_valid & (st_tag_s == tag_s[i]);

        llsc_entry #(
            .TW      (TW),
            .TIMEOUT (TIMEOUT)
        ) u_entry (
            .clk     (clk),
            .reset_n (reset_n),
            .flush   (flush[i]),
            .sc      (sc_req[i]),
            .ll      (ll_req[i]),
            .kill    (kill_s[i]),
            .ll_tag  (ll_tag_s[i]),
            .valid   (valid_s[i]),
            .tag     (tag_s[i])
        );
    end

    // SC candidates: live reservation on the SC's granule, not flushed, not hit by a store this cycle.
    always_comb begin
        sc_cand_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            sc_cand_s[i] = sc_req[i] & valid_s[i] & (tag_s[i] == sc_tag_s[i])
                           & ~flush[i] & ~st_hit_s[i];
        end
    end

    // Arbitration: a lower-index candidate on the same granule blocks this one.
    always_comb begin
        blk_s   = {NCH{1'b0}};
        sc_ok_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            for (int j = 0; j < NCH; j++) begin
                blk_s[i] = blk_s[i] | ((j < i) & sc_cand_s[j] & (sc_tag_s[j] == sc_tag_s[i]));
            end
            sc_ok_s[i] = sc_cand_s[i] & ~blk_s[i];
        end
    end

    // Kill matrix: snooped store to the granule, or another channel's winning SC to it.
    always_comb begin
        kill_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            kill_s[i] = st_hit_s[i];
            for (int j = 0; j < NCH; j++) begin
                kill_s[i] = kill_s[i] | ((j != i) & sc_ok_s[j] & (sc_tag_s[j] == tag_s[i]));
            end
        end
    end

    // sc_ok must read zero throughout reset even though it is combinational.
    always_comb begin
        if (!reset_n) begin
            sc_ok = {NCH{1'b0}};
        end else begin
            sc_ok = sc_ok_s;
        end
    end

    assign llbit = valid_s;

endmodule

// File: tb/tb_llsc_monitor.sv
// Self-checking bench for llsc_monitor: directed scenarios plus random traffic against a reservation model.
module tb_llsc_monitor;

    localparam int NCH = 3;
    localparam int AW  = 16;
    localparam int GB  = 2;
    localparam int TW  = AW - GB;
`ifdef LLSC_TIMEOUT_EN
    localparam int TO  = 8;
`else
    localparam int TO  = 1024;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NCH-1:0]    flush = '0;
    logic [NCH-1:0]    ll_req = '0;
    logic [NCH*AW-1:0] ll_addr = '0;
    logic [NCH-1:0]    sc_req = '0;
    logic [NCH*AW-1:0] sc_addr = '0;
    logic              st_valid = 1'b0;
    logic [AW-1:0]     st_addr = '0;
    logic [NCH-1:0]    sc_ok;
    logic [NCH-1:0]    llbit;

    llsc_monitor #(
        .NCH       (NCH),
        .ADDR_W    (AW),
        .GRAN_BITS (GB),
        .TIMEOUT   (TO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .ll_req   (ll_req),
        .ll_addr  (ll_addr),
        .sc_req   (sc_req),
        .sc_addr  (sc_addr),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .sc_ok    (sc_ok),
        .llbit    (llbit)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int r_s;

    // Reservation model: one (valid, granule, arm cycle) record per channel.
    bit            m_valid [NCH];
    logic [TW-1:0] m_tag   [NCH];
    int            m_arm   [NCH];
    logic [NCH-1:0] eff;
    logic [NCH-1:0] exp_ok;
    logic [NCH-1:0] last_ok;
    logic [TW-1:0]  won [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [TW-1:0] tg(input logic [AW-1:0] a);
        return a[AW-1:GB];
    endfunction

    function automatic bit in_won(input logic [TW-1:0] t);
        foreach (won[k]) if (won[k] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_arm[i]   = 0;
        end
    endtask

    task automatic model_eval();
        logic [TW-1:0] t;
        won.delete();
        exp_ok = '0;
        for (int i = 0; i < NCH; i++) begin
            eff[i] = m_valid[i];
`ifdef LLSC_TIMEOUT_EN
            if (cyc - m_arm[i] > TO + 1) eff[i] = 1'b0;
`endif
        end
        for (int i = 0; i < NCH; i++) begin
            t = tg(sc_addr[i*AW +: AW]);
            if (sc_req[i] && eff[i] && m_tag[i] == t && !flush[i]
                && !(st_valid && tg(st_addr) == m_tag[i])) begin
                if (!in_won(t)) begin
                    exp_ok[i] = 1'b1;
                    won.push_back(t);
                end
            end
        end
    endtask

    task automatic model_update();
        bit kill;
        for (int i = 0; i < NCH; i++) begin
            kill = (st_valid && tg(st_addr) == m_tag[i]) || in_won(m_tag[i]);
            if (flush[i])       m_valid[i] = 1'b0;
            else if (sc_req[i]) m_valid[i] = 1'b0;
            else if (ll_req[i]) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tg(ll_addr[i*AW +: AW]);
                m_arm[i]   = cyc;
            end
            else if (kill)      m_valid[i] = 1'b0;
            else if (!eff[i])   m_valid[i] = 1'b0;
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_eval();
        check("sc_ok", sc_ok, exp_ok);
        check("llbit", llbit, eff);
        last_ok = sc_ok;
        @(posedge clk);
        model_update();
        #1;
        flush    = '0;
        ll_req   = '0;
        sc_req   = '0;
        st_valid = 1'b0;
    endtask

    task automatic set_ll(input int ch, input logic [AW-1:0] a);
        ll_req[ch] = 1'b1;
        ll_addr[ch*AW +: AW] = a;
    endtask

    task automatic set_sc(input int ch, input logic [AW-1:0] a);
        sc_req[ch] = 1'b1;
        sc_addr[ch*AW +: AW] = a;
    endtask

    task automatic set_st(input logic [AW-1:0] a);
        st_valid = 1'b1;
        st_addr  = a;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        return AW'(32'h100 + $urandom_range(0, 15));
    endfunction

    initial begin
        model_clear();
        // Reset state, with SC requests held to confirm sc_ok is gated.
        sc_req = '1;
        #12;
        check("rst_llbit", llbit, 0);
        check("rst_sc_ok", sc_ok, 0);
        sc_req = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 1: LL then SC on the same granule.
        set_ll(0, 16'h0100); tick();
        check("t1_llbit_set", llbit[0], 1);
        set_sc(0, 16'h0100); tick();
        check("t1_sc_ok", last_ok, 3'b001);
        check("t1_llbit_clr", llbit[0], 0);

        // 2: store in the reserved granule kills; a store in the next granule does not.
        set_ll(0, 16'h0100); tick();
        set_st(16'h0102);    tick();
        set_sc(0, 16'h0100); tick();
        check("t2_killed", last_ok[0], 0);
        set_ll(0, 16'h0100); tick();
        set_st(16'h0104);    tick();
        set_sc(0, 16'h0100); tick();
        check("t2_survive", last_ok[0], 1);

        // 3: two channels race on one granule; lowest index wins.
        set_ll(0, 16'h0200); set_ll(1, 16'h0200); tick();
        set_sc(0, 16'h0200); set_sc(1, 16'h0200); tick();
        check("t3_arb", last_ok, 3'b001);
        check("t3_llbits", llbit[1:0], 2'b00);

        // 4: flush beats SC; own LL beats a same-cycle store.
        set_ll(1, 16'h0300); tick();
        set_sc(1, 16'h0300); flush[1] = 1'b1; tick();
        check("t4_flush_ok", last_ok[1], 0);
        check("t4_flush_llbit", llbit[1], 0);
        set_ll(0, 16'h0300); set_st(16'h0300); tick();
        check("t4_ll_beats_st", llbit[0], 1);
        set_sc(0, 16'h0300); tick();

        // 5: long-lived reservation.
`ifdef LLSC_TIMEOUT_EN
        set_ll(0, 16'h0400); tick();
        repeat (TO) tick();
        set_sc(0, 16'h0400); tick();
        check("t5_last_cycle", last_ok[0], 1);
        set_ll(0, 16'h0400); tick();
        repeat (TO + 1) tick();
        set_sc(0, 16'h0400); tick();
        check("t5_expired", last_ok[0], 0);
`else
        set_ll(0, 16'h0400); tick();
        repeat (2000) tick();
        set_sc(0, 16'h0400); tick();
        check("t5_persist", last_ok[0], 1);
`endif

        // 6: asynchronous reset while reserved.
        set_ll(0, 16'h0600); tick();
        check("t6_armed", llbit[0], 1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_llbit", llbit, 0);
        set_sc(0, 16'h0600);
        #1;
        check("t6_rst_sc_ok", sc_ok, 0);
        sc_req = '0;
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        set_sc(0, 16'h0600); tick();
        check("t6_sc_after_rst", last_ok[0], 0);

        // Random traffic on a handful of granules.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                r_s = $urandom_range(0, 15);
                if (r_s < 4)      set_ll(c, rnd_addr());
                else if (r_s < 8) set_sc(c, rnd_addr());
                if ($urandom_range(0, 15) == 0) flush[c] = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) set_st(rnd_addr());
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
